// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Build option: RF_BYPASS_EN enables same-cycle write-to-read forwarding.
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int ZERO_REG      = 0;
    localparam int MAX_WRITE     = 2;

    typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;

    typedef struct packed {
        logic valid;
        logic idx;
    } wr_sel_t;

    // Highest-numbered matching write port owns the address.
    function automatic wr_sel_t wr_pick(input logic [MAX_WRITE-1:0] hit);
        wr_sel_t s;
        s = '0;
        for (int j = 0; j < MAX_WRITE; j++) begin
            if (hit[j]) begin
                s.valid = 1'b1;
                s.idx   = 1'(j);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write busy tracker; a claim in the same cycle as a
// retiring write keeps the register busy. Register 0 never goes busy.
module rf_scoreboard #(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREG-1:0] claim_vec,
    input  logic [NREG-1:0] clear_vec,
    output logic [NREG-1:0] busy_vec
);

    logic [NREG-1:0] busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= ((busy_q & ~clear_vec) | claim_vec) & ~NREG'(1);
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_multiport.sv
// Multi-port integer register file with pending-write scoreboard.
// Build option: RF_BYPASS_EN forwards same-cycle writeback data to reads.
module rf_multiport #(
    parameter int ADDR_WIDTH = 5,
    parameter int XLEN       = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_WRITE  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_READ*ADDR_WIDTH-1:0]  rd_addr,
    output logic [NUM_READ*XLEN-1:0]        rd_data,
    output logic [NUM_READ-1:0]             rd_busy,
    input  logic [NUM_WRITE-1:0]            wr_en,
    input  logic [NUM_WRITE*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WRITE*XLEN-1:0]       wr_data,
    input  logic                            claim_en,
    input  logic [ADDR_WIDTH-1:0]           claim_addr,
    output logic [(2**ADDR_WIDTH)-1:0]      busy_vec
);

    import rf_pkg::*;

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [MAX_WRITE-1:0]  we;
    logic [ADDR_WIDTH-1:0] wa [MAX_WRITE];
    logic [XLEN-1:0]       wd [MAX_WRITE];

    // Unused write ports are tied off so priority logic is uniform.
    for (genvar j = 0; j < MAX_WRITE; j++) begin : g_wport
        if (j < NUM_WRITE) begin : g_on
            assign we[j] = wr_en[j];
            assign wa[j] = wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
            assign wd[j] = wr_data[j*XLEN +: XLEN];
        end else begin : g_off
            assign we[j] = 1'b0;
            assign wa[j] = '0;
            assign wd[j] = '0;
        end
    end

    logic [XLEN-1:0] regs [NREG];
    wr_sel_t         sel  [NREG];
    logic [NREG-1:0] claim_vec;
    logic [NREG-1:0] clear_vec;

    always_comb begin
        logic [MAX_WRITE-1:0] hit;
        claim_vec = '0;
        clear_vec = '0;
        for (int r = 0; r < NREG; r++) begin
            hit = '0;
            for (int j = 0; j < MAX_WRITE; j++) begin
                hit[j] = we[j] && (wa[j] == ADDR_WIDTH'(r))
                         && (r != ZERO_REG);
            end
            sel[r]       = wr_pick(hit);
            clear_vec[r] = sel[r].valid;
        end
        if (claim_en && claim_addr != ADDR_WIDTH'(ZERO_REG)) begin
            claim_vec[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (sel[r].valid) begin
                    regs[r] <= wd[sel[r].idx];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREG(NREG)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .claim_vec(claim_vec),
        .clear_vec(clear_vec),
        .busy_vec (busy_vec)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rport
        logic [ADDR_WIDTH-1:0] ra;
        logic [XLEN-1:0]       data;
        logic                  busy;

        assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
`ifdef RF_BYPASS_EN
            logic [MAX_WRITE-1:0] hit;
            wr_sel_t              s;
`endif
            data = regs[ra];
            busy = busy_vec[ra];
`ifdef RF_BYPASS_EN
            for (int j = 0; j < MAX_WRITE; j++) begin
                hit[j] = we[j] && (wa[j] == ra)
                         && (ra != ADDR_WIDTH'(ZERO_REG));
            end
            s = wr_pick(hit);
            if (s.valid) begin
                data = wd[s.idx];
                if (!(claim_en && claim_addr == ra)) begin
                    busy = 1'b0;
                end
            end
`endif
            // Forwarded data must not leak out while held in reset.
            if (!rst_n) begin
                data = '0;
                busy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = data;
        assign rd_busy[i]              = busy;
    end

endmodule
